// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: shadow-record hazard scheduler for the D/E/M/W pipeline; optional MDU busy sequencer under MDU_CTRL_EN
module hazard_fwd_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_rs_tuse,
  input  logic [1:0] d_rt_tuse,
  input  logic [4:0] d_dst,
  input  logic       d_wen,
  input  logic [1:0] d_tnew,
  input  logic       d_md_use,
  input  logic       e_md_start,
  input  logic       e_md_is_div,
  output logic       stall,
  output logic       e_bubble,
  output logic [1:0] fwd_d_rs,
  output logic [1:0] fwd_d_rt,
  output logic [1:0] fwd_e_rs,
  output logic [1:0] fwd_e_rt,
  output logic       fwd_m_rt,
  output logic       md_busy
);
  logic [4:0] e_rs, e_rt, e_dst, m_rt, m_dst, w_dst;
  logic       e_wen, m_wen, w_wen;
  logic [1:0] e_tnew, m_tnew;
  logic       rst_q, live, md_hold, md_cnt_nz, hz_rs, hz_rt, stall_c;
  logic       e_hit_rs, e_hit_rt, m_hit_rs, m_hit_rt, w_hit_rs, w_hit_rt;
  logic       me_hit_rs, me_hit_rt, we_hit_rs, we_hit_rt, wm_hit_rt;

  function automatic logic hit(input logic wen, input logic [4:0] dst, input logic [4:0] src);
    return wen && (dst != 5'd0) && (dst == src);
  endfunction

  // outputs are forced quiet while reset is high and for the cycle right after it
  assign live = !reset && !rst_q;

  assign e_hit_rs  = hit(e_wen, e_dst, d_rs);
  assign e_hit_rt  = hit(e_wen, e_dst, d_rt);
  assign m_hit_rs  = hit(m_wen, m_dst, d_rs);
  assign m_hit_rt  = hit(m_wen, m_dst, d_rt);
  assign w_hit_rs  = hit(w_wen, w_dst, d_rs);
  assign w_hit_rt  = hit(w_wen, w_dst, d_rt);
  assign me_hit_rs = hit(m_wen, m_dst, e_rs);
  assign me_hit_rt = hit(m_wen, m_dst, e_rt);
  assign we_hit_rs = hit(w_wen, w_dst, e_rs);
  assign we_hit_rt = hit(w_wen, w_dst, e_rt);
  assign wm_hit_rt = hit(w_wen, w_dst, m_rt);

`ifdef MDU_CTRL_EN
  logic [3:0] md_cnt;
  // busy counter: a start (re)loads the latency, otherwise count down and hold at zero
  always_ff @(posedge clk) begin
    if (reset) md_cnt <= 4'd0;
    else if (e_md_start) md_cnt <= e_md_is_div ? 4'(DIV_CYC) : 4'(MULT_CYC);
    else if (md_cnt != 4'd0) md_cnt <= md_cnt - 4'd1;
  end
  assign md_cnt_nz = md_cnt != 4'd0;
  assign md_hold   = d_md_use && (md_cnt_nz || e_md_start);
`else
  logic unused_md;
  assign unused_md = &{1'b0, d_md_use, e_md_start, e_md_is_div};
  assign md_cnt_nz = 1'b0;
  assign md_hold   = 1'b0;
`endif

  // stall when a producer in E or M will not have its result ready by the time D needs it
  always_comb begin
    hz_rs    = (d_rs_tuse != 2'd3) && ((e_hit_rs && e_tnew > d_rs_tuse) || (m_hit_rs && m_tnew > d_rs_tuse));
    hz_rt    = (d_rt_tuse != 2'd3) && ((e_hit_rt && e_tnew > d_rt_tuse) || (m_hit_rt && m_tnew > d_rt_tuse));
    stall_c  = live && (hz_rs || hz_rt || md_hold);
    stall    = stall_c;
    e_bubble = stall_c;
    md_busy  = live && md_cnt_nz;
    fwd_d_rs = !live ? 2'b00 : (e_hit_rs && e_tnew == 2'd0) ? 2'b01 : (m_hit_rs && m_tnew == 2'd0) ? 2'b10 : w_hit_rs ? 2'b11 : 2'b00;
    fwd_d_rt = !live ? 2'b00 : (e_hit_rt && e_tnew == 2'd0) ? 2'b01 : (m_hit_rt && m_tnew == 2'd0) ? 2'b10 : w_hit_rt ? 2'b11 : 2'b00;
    fwd_e_rs = !live ? 2'b00 : (me_hit_rs && m_tnew == 2'd0) ? 2'b10 : we_hit_rs ? 2'b11 : 2'b00;
    fwd_e_rt = !live ? 2'b00 : (me_hit_rt && m_tnew == 2'd0) ? 2'b10 : we_hit_rt ? 2'b11 : 2'b00;
    fwd_m_rt = live && wm_hit_rt;
  end

  // shadow records: E takes D (or a bubble on stall), M and W always shift
  always_ff @(posedge clk) begin
    rst_q <= reset;
    if (reset) begin
      e_rs   <= 5'd0;
      e_rt   <= 5'd0;
      e_dst  <= 5'd0;
      e_wen  <= 1'b0;
      e_tnew <= 2'd0;
      m_rt   <= 5'd0;
      m_dst  <= 5'd0;
      m_wen  <= 1'b0;
      m_tnew <= 2'd0;
      w_dst  <= 5'd0;
      w_wen  <= 1'b0;
    end else begin
      e_rs   <= stall_c ? 5'd0 : d_rs;
      e_rt   <= stall_c ? 5'd0 : d_rt;
      e_dst  <= stall_c ? 5'd0 : d_dst;
      e_wen  <= stall_c ? 1'b0 : d_wen;
      e_tnew <= stall_c ? 2'd0 : d_tnew;
      m_rt   <= e_rt;
      m_dst  <= e_dst;
      m_wen  <= e_wen;
      m_tnew <= (e_tnew == 2'd0) ? 2'd0 : e_tnew - 2'd1;
      w_dst  <= m_dst;
      w_wen  <= m_wen;
    end
  end
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl: table-driven pipeline vectors plus reset and MDU sequences
module tb_hazard_fwd_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] d_rs, d_rt, d_dst;
  logic [1:0] d_rs_tuse, d_rt_tuse, d_tnew;
  logic       d_wen, d_md_use, e_md_start, e_md_is_div;
  logic       stall, e_bubble, fwd_m_rt, md_busy;
  logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
  int         checks = 0;
  int         failures = 0;

`ifdef MDU_CTRL_EN
  localparam bit MDU = 1'b1;
`else
  localparam bit MDU = 1'b0;
`endif

  typedef struct {
    logic [4:0] rs, rt;
    logic [1:0] tus, tut;
    logic [4:0] dst;
    logic       wen;
    logic [1:0] tnew;
    logic       st;
    logic [1:0] fdrs, fdrt, fers, fert;
    logic       fmrt;
  } vec_t;

  vec_t v[$];

  hazard_fwd_ctrl dut (
    .clk(clk), .reset(reset), .d_rs(d_rs), .d_rt(d_rt), .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
    .d_dst(d_dst), .d_wen(d_wen), .d_tnew(d_tnew), .d_md_use(d_md_use), .e_md_start(e_md_start),
    .e_md_is_div(e_md_is_div), .stall(stall), .e_bubble(e_bubble), .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
    .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt), .fwd_m_rt(fwd_m_rt), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input int rs, rt, tus, tut, dst, wen, tnew, st, fdrs, fdrt, fers, fert, fmrt);
    vec_t r;
    r.rs = 5'(rs); r.rt = 5'(rt); r.tus = 2'(tus); r.tut = 2'(tut); r.dst = 5'(dst);
    r.wen = 1'(wen); r.tnew = 2'(tnew); r.st = 1'(st); r.fdrs = 2'(fdrs); r.fdrt = 2'(fdrt);
    r.fers = 2'(fers); r.fert = 2'(fert); r.fmrt = 1'(fmrt);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic st, input logic [1:0] a, b, c, d, input logic m, input logic bz);
    chk({nm, ".stall"}, 8'(stall), 8'(st));
    chk({nm, ".e_bubble"}, 8'(e_bubble), 8'(st));
    chk({nm, ".fwd_d_rs"}, 8'(fwd_d_rs), 8'(a));
    chk({nm, ".fwd_d_rt"}, 8'(fwd_d_rt), 8'(b));
    chk({nm, ".fwd_e_rs"}, 8'(fwd_e_rs), 8'(c));
    chk({nm, ".fwd_e_rt"}, 8'(fwd_e_rt), 8'(d));
    chk({nm, ".fwd_m_rt"}, 8'(fwd_m_rt), 8'(m));
    chk({nm, ".md_busy"}, 8'(md_busy), 8'(bz));
  endtask

  task automatic setd(input int rs, rt, tus, tut, dst, wen, tnew, mu, ms, mdv);
    d_rs = 5'(rs); d_rt = 5'(rt); d_rs_tuse = 2'(tus); d_rt_tuse = 2'(tut); d_dst = 5'(dst);
    d_wen = 1'(wen); d_tnew = 2'(tnew); d_md_use = 1'(mu); e_md_start = 1'(ms); e_md_is_div = 1'(mdv);
  endtask

  task automatic setrand();
    setd(int'($urandom_range(31)), int'($urandom_range(31)), int'($urandom_range(3)), int'($urandom_range(3)),
         int'($urandom_range(31)), int'($urandom_range(1)), int'($urandom_range(2)), int'($urandom_range(1)),
         int'($urandom_range(1)), int'($urandom_range(1)));
  endtask

  initial begin
    int ns, nb;
    // rs rt tus tut dst wen tnew | st fdrs fdrt fers fert fmrt
    v.push_back(mk( 1, 2,1,1, 8,1,1, 0,0,0,0,0,0));
    v.push_back(mk( 8, 3,1,1,10,1,1, 0,0,0,0,0,0));
    v.push_back(mk( 0, 0,3,3, 0,0,0, 0,0,0,2,0,0));
    v.push_back(mk( 8, 0,1,3,11,1,1, 0,3,0,0,0,0));
    v.push_back(mk(29,11,1,2, 0,0,0, 0,0,0,0,0,0));
    v.push_back(mk( 0, 0,3,3, 0,0,0, 0,0,0,0,2,0));
    v.push_back(mk( 0, 0,3,3, 0,0,0, 0,0,0,0,0,1));
    v.push_back(mk(29, 0,1,3, 9,1,2, 0,0,0,0,0,0));
    v.push_back(mk( 5, 9,1,1,12,1,1, 1,0,0,0,0,0));
    v.push_back(mk( 5, 9,1,1,12,1,1, 0,0,0,0,0,0));
    v.push_back(mk( 0, 0,3,3, 0,0,0, 0,0,0,0,3,0));
    v.push_back(mk( 1, 2,1,1, 4,1,1, 0,0,0,0,0,0));
    v.push_back(mk( 4, 0,0,3, 0,0,0, 1,0,0,0,0,0));
    v.push_back(mk( 4, 0,0,3, 0,0,0, 0,2,0,0,0,0));
    v.push_back(mk( 0, 0,3,3,31,1,0, 0,0,0,3,0,0));
    v.push_back(mk(31, 0,0,3, 0,0,0, 0,1,0,0,0,0));
    v.push_back(mk(29, 0,1,3, 7,1,2, 0,0,0,2,0,0));
    v.push_back(mk( 0, 0,3,3, 0,0,0, 0,0,0,0,0,0));
    v.push_back(mk( 7, 0,0,3, 0,0,0, 1,0,0,0,0,0));
    v.push_back(mk( 7, 0,0,3, 0,0,0, 0,3,0,0,0,0));
    v.push_back(mk( 1, 2,1,1, 6,1,1, 0,0,0,0,0,0));
    v.push_back(mk( 3, 3,1,1, 6,1,1, 0,0,0,0,0,0));
    v.push_back(mk( 6, 6,1,1, 0,0,0, 0,2,2,0,0,0));
    v.push_back(mk( 0, 0,3,3, 0,0,0, 0,0,0,2,2,0));
    v.push_back(mk( 0, 0,3,3, 0,1,1, 0,0,0,0,0,1));
    v.push_back(mk( 0, 0,0,0, 0,0,0, 0,0,0,0,0,0));
    v.push_back(mk( 0, 0,1,2, 0,0,0, 0,0,0,0,0,0));
    v.push_back(mk( 0, 0,2,1, 0,1,2, 0,0,0,0,0,0));
    v.push_back(mk( 0, 0,0,0, 0,0,0, 0,0,0,0,0,0));
    v.push_back(mk( 0, 0,0,0, 0,0,0, 0,0,0,0,0,0));

    setrand();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); setrand(); #1;
      chk_all($sformatf("reset%0d", i), 0, 0, 0, 0, 0, 0, 0);
    end
    @(negedge clk); reset = 1'b0; setrand(); #1;
    chk_all("after_reset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); reset = 1'b1; setd(0, 0, 3, 3, 0, 0, 0, 0, 0, 0); #1;
    chk_all("rereset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); reset = 1'b0; #1;
    chk_all("rereset_after", 0, 0, 0, 0, 0, 0, 0);

    foreach (v[i]) begin
      @(negedge clk);
      setd(v[i].rs, v[i].rt, v[i].tus, v[i].tut, v[i].dst, v[i].wen, v[i].tnew, 0, 0, 0);
      #1;
      chk_all($sformatf("row%0d", i), v[i].st, v[i].fdrs, v[i].fdrt, v[i].fers, v[i].fert, v[i].fmrt, 1'b0);
    end

    ns = 0; nb = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk); setd(0, 0, 3, 3, 0, 0, 0, 1, (i == 0) ? 1 : 0, 1); #1;
      if (stall) ns++;
      if (md_busy) nb++;
    end
    chk("div.stall_cycles", 8'(ns), MDU ? 8'd11 : 8'd0);
    chk("div.busy_cycles", 8'(nb), MDU ? 8'd10 : 8'd0);

    ns = 0; nb = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); setd(0, 0, 3, 3, 0, 0, 0, 1, (i == 0) ? 1 : 0, 0); #1;
      if (stall) ns++;
      if (md_busy) nb++;
    end
    chk("mult.stall_cycles", 8'(ns), MDU ? 8'd6 : 8'd0);
    chk("mult.busy_cycles", 8'(nb), MDU ? 8'd5 : 8'd0);

    @(negedge clk); setd(29, 0, 1, 3, 9, 1, 2, 0, 1, 1); #1;
    chk_all("mid.start", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); setd(0, 0, 3, 3, 0, 0, 0, 0, 0, 0); #1;
    chk_all("mid.busy", 0, 0, 0, 0, 0, 0, MDU);
    @(negedge clk); reset = 1'b1; setd(9, 9, 0, 0, 0, 0, 0, 1, 0, 0); #1;
    chk_all("mid.reset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); reset = 1'b0; setd(0, 0, 3, 3, 0, 0, 0, 1, 0, 0); #1;
    chk_all("mid.release", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); setd(9, 9, 0, 0, 0, 0, 0, 1, 0, 0); #1;
    chk_all("mid.cleared", 0, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
